// File: rtl/switch_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_conditioner_pkg
//  Description : Shared definitions for the switch front end: the hold-FSM
//                state encoding and the default timing constants. The mode
//                selector and clock core use the same encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package switch_conditioner_pkg;

    // Hold FSM state encoding shared with downstream consumers.
    typedef enum logic [1:0] {
        HOLD_IDLE    = 2'b00,
        HOLD_PRESSED = 2'b01,
        HOLD_HELD    = 2'b10
    } hold_state_e;

    // Default timing, in tick units (tick is the 100 Hz sample strobe).
    localparam int unsigned DEF_N_SW           = 3;
    localparam int unsigned DEF_DEBOUNCE_TICKS = 3;
    localparam int unsigned DEF_LONG_TICKS     = 100;
    localparam int unsigned DEF_REPEAT_TICKS   = 20;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage : switch_conditioner_pkg
`default_nettype wire

// File: rtl/switch_conditioner_channel.sv
`default_nettype none
// ============================================================================
//  Module      : switch_conditioner_channel
//  Description : One switch channel: 2-FF synchronizer (polarity normalised,
//                1 = pressed), tick-sampled debouncer and hold FSM producing
//                press / release / long-press / auto-repeat pulses.
//  Ports       : clk, rst_n (async, active-low), tick (sample strobe),
//                sw_raw (raw pin) -> sw_level, press, release_pulse,
//                long_press, repeat_pulse (all registered).
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_conditioner_channel
    import switch_conditioner_pkg::*;
#(
    parameter bit          ACTIVE_LOW     = 1'b1,
    parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int unsigned LONG_TICKS     = DEF_LONG_TICKS,
    parameter int unsigned REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic sw_raw,
    output logic sw_level,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned HOLD_W = $clog2(max_u(LONG_TICKS, REPEAT_TICKS));

    localparam logic [DB_W-1:0]   DB_TERM     = DB_W'(DEBOUNCE_TICKS);
    localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_TICKS - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_TICKS - 1);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              level_q, level_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [DB_W-1:0]   db_cnt_inc;
    hold_state_e       state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;
    logic              level_rise, level_fall;

    // Synchronizer + debouncer. Normalising before the first flop means the
    // synchronizer's reset value (0) reads as "released" for either polarity.
    always_comb begin
        sync1_d    = ACTIVE_LOW ? ~sw_raw : sw_raw;
        sync2_d    = sync1_q;
        level_d    = level_q;
        db_cnt_d   = db_cnt_q;
        db_cnt_inc = db_cnt_q + 1'b1;
        if (tick) begin
            if (sync2_q != level_q) begin
                // The Nth consecutive disagreeing sample flips the level on
                // this very tick edge.
                if (db_cnt_inc == DB_TERM) begin
                    level_d  = ~level_q;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_inc;
                end
            end else begin
                db_cnt_d = '0;
            end
        end
    end

    // Edges are taken from the next-state level so press/release land on the
    // same clk edge as the sw_level change.
    assign level_rise = level_d & ~level_q;
    assign level_fall = ~level_d & level_q;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;
        case (state_q)
            HOLD_IDLE: begin
                if (level_rise) begin
                    state_d    = HOLD_PRESSED;
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            HOLD_PRESSED: begin
                // A release wins over a coinciding long-press terminal count.
                if (level_fall) begin
                    state_d    = HOLD_IDLE;
                    release_d  = 1'b1;
                    hold_cnt_d = '0;
                end else if (tick) begin
                    if (hold_cnt_q == LONG_LAST) begin
                        state_d    = HOLD_HELD;
                        long_d     = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            HOLD_HELD: begin
                if (level_fall) begin
                    state_d    = HOLD_IDLE;
                    release_d  = 1'b1;
                    hold_cnt_d = '0;
                end else if (tick) begin
                    if (hold_cnt_q == REPEAT_LAST) begin
                        repeat_d   = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = HOLD_IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            level_q    <= 1'b0;
            db_cnt_q   <= '0;
            state_q    <= HOLD_IDLE;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
        end
    end

    assign sw_level      = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;

endmodule : switch_conditioner_channel
`default_nettype wire

// File: rtl/switch_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : switch_conditioner
//  Description : Front end for the watch push-switches. Generates N_SW
//                independent channels, each delivering a debounced level and
//                single-clk press / release / long-press / repeat pulses.
//  Ports       : clk, rst_n (async, active-low), tick (sample strobe),
//                sw_raw[N_SW] -> sw_level, press, release_pulse, long_press,
//                repeat_pulse (each N_SW wide). The release event is named
//                release_pulse because "release" is a SystemVerilog keyword.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int unsigned N_SW           = DEF_N_SW,
    parameter bit          ACTIVE_LOW     = 1'b1,
    parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int unsigned LONG_TICKS     = DEF_LONG_TICKS,
    parameter int unsigned REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_level,
    output logic [N_SW-1:0] press,
    output logic [N_SW-1:0] release_pulse,
    output logic [N_SW-1:0] long_press,
    output logic [N_SW-1:0] repeat_pulse
);

    genvar i;
    generate
        for (i = 0; i < N_SW; i++) begin : g_ch
            switch_conditioner_channel #(
                .ACTIVE_LOW     (ACTIVE_LOW),
                .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
                .LONG_TICKS     (LONG_TICKS),
                .REPEAT_TICKS   (REPEAT_TICKS)
            ) u_channel (
                .clk           (clk),
                .rst_n         (rst_n),
                .tick          (tick),
                .sw_raw        (sw_raw[i]),
                .sw_level      (sw_level[i]),
                .press         (press[i]),
                .release_pulse (release_pulse[i]),
                .long_press    (long_press[i]),
                .repeat_pulse  (repeat_pulse[i])
            );
        end
    endgenerate

endmodule : switch_conditioner
`default_nettype wire

// File: tb/tb_switch_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_conditioner
//  Description : Self-checking bench for switch_conditioner. A reference
//                model predicts event pulses into a scoreboard queue; a
//                monitor compares them against the DUT outputs each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_conditioner;

    localparam int DB   = 3;
    localparam int LONG = 100;
    localparam int REP  = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [2:0] sw_raw;
    logic [2:0] sw_level, press, release_pulse, long_press, repeat_pulse;

    switch_conditioner #(
        .N_SW(3), .ACTIVE_LOW(1'b1), .DEBOUNCE_TICKS(DB),
        .LONG_TICKS(LONG), .REPEAT_TICKS(REP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .sw_raw(sw_raw),
        .sw_level(sw_level), .press(press), .release_pulse(release_pulse),
        .long_press(long_press), .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // ---------------- tick generator: every 4th clk, or always high -------
    int tick_mode = 0;
    int tick_div  = 0;
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_mode != 0) tick = 1'b1;
            else begin
                tick_div = (tick_div + 1) % 4;
                tick = (tick_div == 0);
            end
        end
    end

    // ---------------- reference model -------------------------------------
    typedef struct {
        int       cyc;
        logic [2:0] pr, rl, lp, rp;
    } ev_t;
    ev_t sb[$];

    logic [2:0] m_p1, m_p2, m_lvl;   // pin one / two clks ago, pressed = 1
    int  m_run[3];                   // consecutive tick samples disagreeing with level
    int  m_held[3];                  // ticks elapsed since the press tick
    bit  m_hold[3];

    task automatic model_clear();
        m_p1 = '0; m_p2 = '0; m_lvl = '0;
        for (int c = 0; c < 3; c++) begin
            m_run[c] = 0; m_held[c] = 0; m_hold[c] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [2:0] samp;
        ev_t e;
        bit  flipped;
        if (!rst_n) begin
            model_clear();
            return;
        end
        samp = m_p2;
        m_p2 = m_p1;
        m_p1 = ~sw_raw;
        e.cyc = cyc; e.pr = '0; e.rl = '0; e.lp = '0; e.rp = '0;
        if (tick) begin
            for (int c = 0; c < 3; c++) begin
                flipped = 1'b0;
                if (samp[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB) begin
                        flipped  = 1'b1;
                        m_run[c] = 0;
                        m_lvl[c] = ~m_lvl[c];
                        if (m_lvl[c]) begin
                            e.pr[c] = 1'b1; m_hold[c] = 1'b1; m_held[c] = 0;
                        end else begin
                            e.rl[c] = 1'b1; m_hold[c] = 1'b0;
                        end
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (!flipped && m_hold[c]) begin
                    m_held[c]++;
                    if (m_held[c] == LONG) e.lp[c] = 1'b1;
                    else if (m_held[c] > LONG && ((m_held[c] - LONG) % REP) == 0) e.rp[c] = 1'b1;
                end
            end
        end
        if ((e.pr | e.rl | e.lp | e.rp) != 3'b000) sb.push_back(e);
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    initial forever begin
        @(negedge rst_n);
        model_clear();
    end

    // ---------------- monitor / scoreboard compare ------------------------
    int cnt_press[3], cnt_rel[3], cnt_long[3], cnt_rep[3];
    int last_press_cyc[3];
    bit all3_seen;
    bit lvl1_seen;

    task automatic clear_stats();
        for (int c = 0; c < 3; c++) begin
            cnt_press[c] = 0; cnt_rel[c] = 0; cnt_long[c] = 0; cnt_rep[c] = 0;
            last_press_cyc[c] = -1;
        end
        all3_seen = 1'b0;
        lvl1_seen = 1'b0;
    endtask

    initial begin
        ev_t e;
        clear_stats();
        forever begin
            @(negedge clk);
            n_checks++;
            if (sw_level !== m_lvl) begin
                n_err++;
                $display("FAIL sw_level cyc=%0d got=%b exp=%b", cyc, sw_level, m_lvl);
            end
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                n_checks++; n_err++;
                $display("FAIL missed_event cyc=%0d got=none exp_press=%b", e.cyc, e.pr);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (press !== e.pr || release_pulse !== e.rl ||
                    long_press !== e.lp || repeat_pulse !== e.rp) begin
                    n_err++;
                    $display("FAIL events cyc=%0d got p/r/l/rp=%b/%b/%b/%b exp=%b/%b/%b/%b",
                             cyc, press, release_pulse, long_press, repeat_pulse,
                             e.pr, e.rl, e.lp, e.rp);
                end
            end else if ((press | release_pulse | long_press | repeat_pulse) !== 3'b000) begin
                n_checks++; n_err++;
                $display("FAIL unexpected_event cyc=%0d got p/r/l/rp=%b/%b/%b/%b exp=000",
                         cyc, press, release_pulse, long_press, repeat_pulse);
            end
            for (int c = 0; c < 3; c++) begin
                if (press[c] === 1'b1) begin cnt_press[c]++; last_press_cyc[c] = cyc; end
                if (release_pulse[c] === 1'b1) cnt_rel[c]++;
                if (long_press[c] === 1'b1)    cnt_long[c]++;
                if (repeat_pulse[c] === 1'b1)  cnt_rep[c]++;
            end
            if (press === 3'b111) all3_seen = 1'b1;
            if (sw_level[1] === 1'b1) lvl1_seen = 1'b1;
        end
    end

    // ---------------- helpers ---------------------------------------------
    task automatic check_eq(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (tick) k++;
        end
        #1;
    endtask

    task automatic check_outputs_zero(input string name);
        @(negedge clk);
        check_eq({name, "_level"}, int'(sw_level), 0);
        check_eq({name, "_events"},
                 int'(press | release_pulse | long_press | repeat_pulse), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus --------------------------------------------
    initial begin
        int c0;
        bit got;
        rst_n  = 1'b0;
        sw_raw = 3'b111;
        wait_clk(4);
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        wait_clk(4);

        // Basic press / release on channel 0 with periodic ticks.
        clear_stats();
        sw_raw[0] = 1'b0;
        wait_ticks(10);
        sw_raw[0] = 1'b1;
        wait_ticks(10);
        check_eq("ch0_press_count", cnt_press[0], 1);
        check_eq("ch0_release_count", cnt_rel[0], 1);

        // 1-tick and 2-tick glitches on channel 1.
        clear_stats();
        sw_raw[1] = 1'b0; wait_ticks(1);
        sw_raw[1] = 1'b1; wait_ticks(6);
        sw_raw[1] = 1'b0; wait_ticks(2);
        sw_raw[1] = 1'b1; wait_ticks(6);
        check_eq("glitch_press_count", cnt_press[1], 0);
        check_eq("glitch_level_seen", int'(lvl1_seen), 0);

        // Long hold on channel 2: one long press, two repeats.
        clear_stats();
        sw_raw[2] = 1'b0; wait_ticks(150);
        sw_raw[2] = 1'b1; wait_ticks(30);
        check_eq("hold_press_count", cnt_press[2], 1);
        check_eq("hold_long_count", cnt_long[2], 1);
        check_eq("hold_repeat_count", cnt_rep[2], 2);
        check_eq("hold_release_count", cnt_rel[2], 1);

        // Simultaneous presses.
        clear_stats();
        sw_raw = 3'b000; wait_ticks(10);
        check_eq("simultaneous_press", int'(all3_seen), 1);
        sw_raw = 3'b111; wait_ticks(10);

        // Reset in the middle of a hold, pin still pressed afterwards.
        sw_raw[0] = 1'b0; wait_ticks(50);
        rst_n = 1'b0;
        clear_stats();
        check_outputs_zero("mid_hold_reset_a");
        check_outputs_zero("mid_hold_reset_b");
        rst_n = 1'b1;
        wait_ticks(10);
        check_eq("reset_no_release", cnt_rel[0], 0);
        check_eq("reset_fresh_press", cnt_press[0], 1);
        sw_raw[0] = 1'b1; wait_ticks(10);

        // Tick tied high: press lands 2 sync + 3 sample clks after the pin.
        tick_mode = 1;
        wait_clk(10);
        clear_stats();
        c0 = cyc;
        sw_raw[1] = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (cnt_press[1] > 0) got = 1'b1;
        end
        check_eq("tickhigh_press_seen", int'(got), 1);
        if (got) check_eq("tickhigh_latency", last_press_cyc[1] - c0, 5);
        @(posedge clk); #1;
        sw_raw[1] = 1'b1;
        wait_clk(10);

        // Randomised stretch against the model.
        for (int s = 0; s < 220; s++) begin
            if ($urandom_range(0, 9) == 0) tick_mode = int'($urandom_range(0, 1));
            sw_raw = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0; wait_clk(2); rst_n = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) wait_clk(int'($urandom_range(100, 300)));
            else wait_clk(int'($urandom_range(1, 16)));
        end

        sw_raw = 3'b111;
        tick_mode = 1;
        wait_clk(20);
        check_eq("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule : tb_switch_conditioner
`default_nettype wire
